// File: rtl/vmac_pkg.sv
// Shared types and helpers for the multi-lane vector MAC: lane byte width,
// per-beat precision modes and the signed accumulator bounds.
package vmac_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    INT8   = 2'b00,
    INT4X2 = 2'b01,
    UINT8  = 2'b10,
    RSVD   = 2'b11
  } vmac_mode_e;

  typedef struct packed {
    logic signed [63:0] min_v;
    logic signed [63:0] max_v;
  } acc_bounds_t;

  // Widths up to 64 bits are supported; callers truncate to their own width.
  function automatic acc_bounds_t acc_bounds(input int unsigned acc_w);
    acc_bounds_t b;
    b.max_v = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
    b.min_v = -(64'sd1 <<< (acc_w - 32'd1));
    return b;
  endfunction

endpackage

// File: rtl/vector_mac_array_if.sv
// Operand-in / result-out bundle of the vector MAC; master drives operands
// and result acceptance, slave is the MAC itself.
interface vector_mac_array_if
  import vmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);

  logic                     clear;
  logic [1:0]               mode;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*LANE_W-1:0]  in_a;
  logic [LANES*LANE_W-1:0]  in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*ACC_W-1:0]   out_acc;
  logic [LANES-1:0]         out_overflow;
  logic [CNT_W-1:0]         out_beats;

  modport master (
    output clear, mode, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_overflow, out_beats
  );

  modport slave (
    input  clear, mode, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_overflow, out_beats
  );

endinterface

// File: rtl/vmac_lane.sv
// One MAC lane: precision-dependent product, overflow-aware accumulate with
// optional saturation, and the lane accumulator plus sticky overflow flag.
module vmac_lane
  import vmac_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_last,
  input  logic [1:0]        i_mode,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam acc_bounds_t      BOUNDS  = acc_bounds(ACC_W);
  localparam logic [ACC_W-1:0] ACC_MAX = BOUNDS.max_v[ACC_W-1:0];
  localparam logic [ACC_W-1:0] ACC_MIN = BOUNDS.min_v[ACC_W-1:0];

  logic signed [15:0] w_p_int8;
  logic signed [7:0]  w_p_lo;
  logic signed [7:0]  w_p_hi;
  logic signed [8:0]  w_p_int4;
  logic [15:0]        w_p_uint8;
  logic [16:0]        w_prod;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf_beat;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  assign w_p_int8  = $signed(i_a) * $signed(i_b);
  assign w_p_lo    = $signed(i_a[3:0]) * $signed(i_b[3:0]);
  assign w_p_hi    = $signed(i_a[7:4]) * $signed(i_b[7:4]);
  assign w_p_int4  = {w_p_lo[7], w_p_lo} + {w_p_hi[7], w_p_hi};
  assign w_p_uint8 = i_a * i_b;

  // Product select as a 17-bit signed value; reserved mode falls back to INT8.
  always_comb begin
    w_prod = {w_p_int8[15], w_p_int8};
    case (vmac_mode_e'(i_mode))
      INT4X2:  w_prod = {{8{w_p_int4[8]}}, w_p_int4};
      UINT8:   w_prod = {1'b0, w_p_uint8};
      default: w_prod = {w_p_int8[15], w_p_int8};
    endcase
  end

  // One guard bit suffices: |product| < 2^16 <= 2^(ACC_W-2).
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-16){w_prod[16]}}, w_prod};
  assign w_ovf_beat = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign o_ovf      = r_ovf | w_ovf_beat;

  // Clamp toward the true sign on overflow, otherwise keep the wrapped sum.
  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (w_ovf_beat && (SATURATE != 0)) begin
      o_sum = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      o_sum = w_sum[ACC_W-1:0];
    end
  end

  // Accumulator restarts from zero after the last beat of each vector.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= {ACC_W{1'b0}};
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= i_last ? {ACC_W{1'b0}} : o_sum;
      r_ovf <= i_last ? 1'b0 : o_ovf;
    end
  end

endmodule

// File: rtl/vector_mac_array.sv
// Multi-lane integer dot-product engine: input register stage, per-lane
// accumulators, beat counter and a valid/ready result register.
module vector_mac_array
  import vmac_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  vector_mac_array_if.slave  bus
);

  logic                     w_advance;
  logic                     w_fire;
  logic                     w_done;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [LANES*ACC_W-1:0]   w_sum;
  logic [LANES-1:0]         w_ovf;

  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic [1:0]               r_s1_mode;
  logic [LANES*LANE_W-1:0]  r_s1_a;
  logic [LANES*LANE_W-1:0]  r_s1_b;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_out_valid;
  logic [LANES*ACC_W-1:0]   r_out_acc;
  logic [LANES-1:0]         r_out_ovf;
  logic [CNT_W-1:0]         r_out_beats;

  assign w_advance  = !(r_out_valid && !bus.out_ready);
  assign w_fire     = r_s1_valid && w_advance && !bus.clear;
  assign w_done     = w_fire && r_s1_last;
  assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1'b1);

  assign bus.in_ready     = w_advance && !bus.clear && !rst;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_acc      = r_out_acc;
  assign bus.out_overflow = r_out_ovf;
  assign bus.out_beats    = r_out_beats;

  // S1 operand register; holds its beat while the output is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= 2'b00;
      r_s1_a     <= {(LANES*LANE_W){1'b0}};
      r_s1_b     <= {(LANES*LANE_W){1'b0}};
    end else if (bus.clear) begin
      r_s1_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_last <= bus.in_last;
        r_s1_mode <= bus.mode;
        r_s1_a    <= bus.in_a;
        r_s1_b    <= bus.in_b;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vmac_lane #(
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_clear (bus.clear),
      .i_en    (w_fire),
      .i_last  (r_s1_last),
      .i_mode  (r_s1_mode),
      .i_a     (r_s1_a[LANE_W*k +: LANE_W]),
      .i_b     (r_s1_b[LANE_W*k +: LANE_W]),
      .o_sum   (w_sum[ACC_W*k +: ACC_W]),
      .o_ovf   (w_ovf[k])
    );
  end

  // Beat counter saturates at all-ones and restarts after each vector.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_fire) begin
      r_cnt <= r_s1_last ? {CNT_W{1'b0}} : w_cnt_next;
    end
  end

  // A new result may replace the one being accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= {(LANES*ACC_W){1'b0}};
      r_out_ovf   <= {LANES{1'b0}};
      r_out_beats <= {CNT_W{1'b0}};
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_sum;
      r_out_ovf   <= w_ovf;
      r_out_beats <= w_cnt_next;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_mac_array.sv
// Directed self-checking bench: one main 4-lane instance plus two 18-bit
// accumulator instances (saturating and wrapping) for the overflow cases.
module tb_vector_mac_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  vector_mac_array_if #(.LANES(4), .ACC_W(32), .CNT_W(16)) bus_m ();
  vector_mac_array_if #(.LANES(2), .ACC_W(18), .CNT_W(16)) bus_s ();
  vector_mac_array_if #(.LANES(2), .ACC_W(18), .CNT_W(16)) bus_w ();

  vector_mac_array #(.LANES(4), .ACC_W(32), .SATURATE(1), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .bus(bus_m));
  vector_mac_array #(.LANES(2), .ACC_W(18), .SATURATE(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_s));
  vector_mac_array #(.LANES(2), .ACC_W(18), .SATURATE(0), .CNT_W(16)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus_w));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] md, input logic last);
    bus_m.in_valid = v;
    bus_m.in_a     = a;
    bus_m.in_b     = b;
    bus_m.mode     = md;
    bus_m.in_last  = last;
  endtask

  task automatic drive_o(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic last);
    bus_s.in_valid = v;  bus_w.in_valid = v;
    bus_s.in_a     = a;  bus_w.in_a     = a;
    bus_s.in_b     = b;  bus_w.in_b     = b;
    bus_s.in_last  = last;
    bus_w.in_last  = last;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (bus_m.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus_m.in_ready); else passed++;
    checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus_m.out_valid); else passed++;
    checks++; if (bus_m.out_acc !== 128'd0) $display("FAIL reset_out_acc got %h exp 0", bus_m.out_acc); else passed++;
    checks++; if (bus_m.out_beats !== 16'd0) $display("FAIL reset_out_beats got %0d exp 0", bus_m.out_beats); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus_m.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b exp 1", bus_m.in_ready); else passed++;
  endtask

  task automatic test_int8();
    bus_m.out_ready = 1'b1;
    drive_m(1'b1, 32'h0000_0380, 32'h0000_0580, 2'b00, 1'b0); step();
    step();
    drive_m(1'b1, 32'h0000_0380, 32'h0000_0580, 2'b00, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL int8_early_valid got %b exp 0", bus_m.out_valid); else passed++;
    step();
    checks++; if (bus_m.out_valid !== 1'b1) $display("FAIL int8_valid got %b exp 1", bus_m.out_valid); else passed++;
    checks++; if (bus_m.out_acc[31:0] !== 32'd49152) $display("FAIL int8_lane0 got %0d exp 49152", bus_m.out_acc[31:0]); else passed++;
    checks++; if (bus_m.out_acc[63:32] !== 32'd45) $display("FAIL int8_lane1 got %0d exp 45", bus_m.out_acc[63:32]); else passed++;
    checks++; if (bus_m.out_acc[127:64] !== 64'd0) $display("FAIL int8_lane23 got %h exp 0", bus_m.out_acc[127:64]); else passed++;
    checks++; if (bus_m.out_overflow !== 4'b0000) $display("FAIL int8_ovf got %b exp 0000", bus_m.out_overflow); else passed++;
    checks++; if (bus_m.out_beats !== 16'd3) $display("FAIL int8_beats got %0d exp 3", bus_m.out_beats); else passed++;
    step();
    checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL int8_release got %b exp 0", bus_m.out_valid); else passed++;
  endtask

  task automatic test_modes();
    bus_m.out_ready = 1'b1;
    drive_m(1'b1, 32'h0000_0088, 32'h0000_0088, 2'b01, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0); step();
    checks++; if (bus_m.out_acc[31:0] !== 32'd128) $display("FAIL int4_max got %0d exp 128", $signed(bus_m.out_acc[31:0])); else passed++;
    checks++; if (bus_m.out_beats !== 16'd1) $display("FAIL int4_beats got %0d exp 1", bus_m.out_beats); else passed++;
    drive_m(1'b1, 32'h0000_0077, 32'h0000_0088, 2'b01, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0); step();
    checks++; if (bus_m.out_acc[31:0] !== 32'hFFFF_FF90) $display("FAIL int4_min got %0d exp -112", $signed(bus_m.out_acc[31:0])); else passed++;
    // UINT8 beat followed by a reserved-mode (signed) beat in the same vector
    drive_m(1'b1, 32'h0000_00FF, 32'h0000_00FF, 2'b10, 1'b0); step();
    drive_m(1'b1, 32'h0000_00FF, 32'h0000_0002, 2'b11, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0); step();
    checks++; if (bus_m.out_acc[31:0] !== 32'd65023) $display("FAIL mixed_mode got %0d exp 65023", $signed(bus_m.out_acc[31:0])); else passed++;
    checks++; if (bus_m.out_beats !== 16'd2) $display("FAIL mixed_beats got %0d exp 2", bus_m.out_beats); else passed++;
    step();
  endtask

  task automatic test_overflow();
    bus_s.out_ready = 1'b1;
    bus_w.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_o(1'b1, (i == 8) ? 16'h0100 : 16'h0180, (i == 8) ? 16'h0100 : 16'h0180, i == 8);
      step();
    end
    drive_o(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    checks++; if (bus_s.out_valid !== 1'b1) $display("FAIL sat_valid got %b exp 1", bus_s.out_valid); else passed++;
    checks++; if (bus_s.out_acc[17:0] !== 18'h1FFFF) $display("FAIL sat_lane0 got %h exp 1ffff", bus_s.out_acc[17:0]); else passed++;
    checks++; if (bus_s.out_acc[35:18] !== 18'd9) $display("FAIL sat_lane1 got %0d exp 9", bus_s.out_acc[35:18]); else passed++;
    checks++; if (bus_s.out_overflow !== 2'b01) $display("FAIL sat_ovf got %b exp 01", bus_s.out_overflow); else passed++;
    checks++; if (bus_s.out_beats !== 16'd9) $display("FAIL sat_beats got %0d exp 9", bus_s.out_beats); else passed++;
    checks++; if (bus_w.out_acc[17:0] !== 18'h20000) $display("FAIL wrap_lane0 got %h exp 20000", bus_w.out_acc[17:0]); else passed++;
    checks++; if (bus_w.out_overflow !== 2'b01) $display("FAIL wrap_ovf got %b exp 01", bus_w.out_overflow); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    bus_m.out_ready = 1'b0;
    drive_m(1'b1, 32'h0000_0002, 32'h0000_0003, 2'b00, 1'b0); step();
    drive_m(1'b1, 32'h0000_0004, 32'h0000_0005, 2'b00, 1'b1); step();
    drive_m(1'b1, 32'h0000_00FF, 32'h0000_0007, 2'b00, 1'b0); step();
    drive_m(1'b1, 32'h0000_000A, 32'h0000_000A, 2'b00, 1'b1);
    #1;
    checks++; if (bus_m.out_valid !== 1'b1) $display("FAIL b2b_first_valid got %b exp 1", bus_m.out_valid); else passed++;
    checks++; if (bus_m.in_ready !== 1'b0) $display("FAIL b2b_in_ready_drop got %b exp 0", bus_m.in_ready); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_acc[31:0] !== 32'd26 ||
          bus_m.out_beats !== 16'd2 || bus_m.in_ready !== 1'b0)
        $display("FAIL b2b_hold[%0d] got v=%b acc=%0d beats=%0d rdy=%b exp v=1 acc=26 beats=2 rdy=0",
                 i, bus_m.out_valid, bus_m.out_acc[31:0], bus_m.out_beats, bus_m.in_ready);
      else passed++;
    end
    bus_m.out_ready = 1'b1;
    #1;
    checks++; if (bus_m.in_ready !== 1'b1) $display("FAIL b2b_resume_ready got %b exp 1", bus_m.in_ready); else passed++;
    step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL b2b_gap_valid got %b exp 0", bus_m.out_valid); else passed++;
    step();
    checks++; if (bus_m.out_valid !== 1'b1) $display("FAIL b2b_second_valid got %b exp 1", bus_m.out_valid); else passed++;
    checks++; if (bus_m.out_acc[31:0] !== 32'd93) $display("FAIL b2b_second_acc got %0d exp 93", $signed(bus_m.out_acc[31:0])); else passed++;
    checks++; if (bus_m.out_beats !== 16'd2) $display("FAIL b2b_second_beats got %0d exp 2", bus_m.out_beats); else passed++;
    step();
  endtask

  task automatic test_clear();
    bus_m.out_ready = 1'b1;
    drive_m(1'b1, 32'h0000_0002, 32'h0000_0002, 2'b00, 1'b0); step();
    drive_m(1'b1, 32'h0000_0001, 32'h0000_0001, 2'b00, 1'b0); step();
    drive_m(1'b1, 32'h0000_0005, 32'h0000_0005, 2'b00, 1'b1);
    bus_m.clear = 1'b1;
    #1;
    checks++; if (bus_m.in_ready !== 1'b0) $display("FAIL clear_in_ready got %b exp 0", bus_m.in_ready); else passed++;
    step();
    bus_m.clear = 1'b0;
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL clear_no_result[%0d] got %b exp 0", i, bus_m.out_valid); else passed++;
    end
    drive_m(1'b1, 32'h0000_0003, 32'h0000_0003, 2'b00, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0); step();
    checks++; if (bus_m.out_acc[31:0] !== 32'd9) $display("FAIL clear_fresh_acc got %0d exp 9", $signed(bus_m.out_acc[31:0])); else passed++;
    checks++; if (bus_m.out_beats !== 16'd1) $display("FAIL clear_fresh_beats got %0d exp 1", bus_m.out_beats); else passed++;
    step();
  endtask

  task automatic test_uint8_rst();
    bus_m.out_ready = 1'b0;
    drive_m(1'b1, 32'h00FF_0000, 32'h00FF_0000, 2'b10, 1'b1); step();
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0); step();
    checks++; if (bus_m.out_acc[95:64] !== 32'd65025) $display("FAIL uint8_lane2 got %0d exp 65025", bus_m.out_acc[95:64]); else passed++;
    checks++; if (bus_m.out_beats !== 16'd1) $display("FAIL uint8_beats got %0d exp 1", bus_m.out_beats); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bus_m.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", bus_m.in_ready); else passed++;
    step();
    checks++; if (bus_m.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus_m.out_valid); else passed++;
    checks++; if (bus_m.out_acc !== 128'd0) $display("FAIL rst_out_acc got %h exp 0", bus_m.out_acc); else passed++;
    checks++; if (bus_m.out_beats !== 16'd0) $display("FAIL rst_out_beats got %0d exp 0", bus_m.out_beats); else passed++;
    rst = 1'b0;
    bus_m.out_ready = 1'b1;
    step();
  endtask

  initial begin
    bus_m.clear = 1'b0; bus_m.out_ready = 1'b0;
    bus_s.clear = 1'b0; bus_s.out_ready = 1'b0; bus_s.mode = 2'b00;
    bus_w.clear = 1'b0; bus_w.out_ready = 1'b0; bus_w.mode = 2'b00;
    drive_m(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive_o(1'b0, 16'h0, 16'h0, 1'b0);
    test_reset();
    test_int8();
    test_modes();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_uint8_rst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
